// File: rtl/soma_scan.sv
`default_nettype none
// ==================================================================
// soma_scan : per-tik Vm threshold scan with SD clear and spike out
// Revision  : 1.0
// ==================================================================
module soma_scan #(
   parameter int NNW = 12,
   parameter int VW  = 20
) (
   input  logic           clk_SD,
   input  logic           rst_n,
   input  logic           tik,
   input  logic           cfg_en,
   input  logic [NNW-1:0] cfg_neuron_max,
   input  logic [VW-1:0]  cfg_vth,
   output logic [NNW-1:0] soma_sd_vm_addr,
   output logic           soma_sd_vld,
   output logic           soma_sd_clear,
   input  logic [VW-1:0]  sd_soma_vm,
   output logic [NNW-1:0] spk_id,
   output logic           spk_vld,
   input  logic           spk_rdy,
   output logic           busy,
   output logic           done,
   output logic           overrun
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_EVAL = 3'd2,
      S_HOLD = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [NNW-1:0] n_q, n_d;
   logic [NNW-1:0] max_q, max_d;
   logic [VW-1:0]  vth_q, vth_d;
   logic [NNW-1:0] spk_id_q, spk_id_d;
   logic           spk_vld_q, spk_vld_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           overrun_q, overrun_d;

   logic fire, can_load, load, adv, rd_strobe;

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      max_d     = max_q;
      vth_d     = vth_q;
      spk_id_d  = spk_id_q;
      done_d    = 1'b0;
      load      = 1'b0;
      adv       = 1'b0;
      rd_strobe = 1'b0;
      fire      = $signed(sd_soma_vm) >= $signed(vth_q);
      can_load  = ~spk_vld_q | spk_rdy;
      spk_vld_d = spk_vld_q & ~spk_rdy;
      overrun_d = overrun_q | (tik & (state_q != S_IDLE));

      case (state_q)
         S_IDLE: begin
            if (tik && cfg_en) begin
               state_d = S_READ;
               n_d     = '0;
               max_d   = cfg_neuron_max;
               vth_d   = cfg_vth;
            end
         end
         S_READ: begin
            rd_strobe = 1'b1;
            state_d   = S_EVAL;
         end
         S_EVAL: begin
            // A firing neuron stalls only when the spike slot cannot take it now;
            // the clear is deferred so Vm is never lost without a spike.
            if (fire && !can_load) begin
               state_d = S_HOLD;
            end else begin
               load = fire;
               adv  = 1'b1;
            end
         end
         S_HOLD: begin
            if (spk_rdy) begin
               load = 1'b1;
               adv  = 1'b1;
            end
         end
         S_FIN: begin
            if (!spk_vld_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         spk_vld_d = 1'b1;
         spk_id_d  = n_q;
      end
      if (adv) begin
         if (n_q == max_q) begin
            state_d = S_FIN;
            done_d  = 1'b1;
         end else begin
            n_d     = n_q + NNW'(1);
            state_d = S_READ;
         end
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_SD or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         max_q     <= '0;
         vth_q     <= '0;
         spk_id_q  <= '0;
         spk_vld_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         max_q     <= max_d;
         vth_q     <= vth_d;
         spk_id_q  <= spk_id_d;
         spk_vld_q <= spk_vld_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   assign soma_sd_vld     = rd_strobe | load;
   assign soma_sd_clear   = load;
   assign soma_sd_vm_addr = (rd_strobe | load) ? n_q : '0;
   assign spk_id          = spk_id_q;
   assign spk_vld         = spk_vld_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign overrun         = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_soma_scan.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for soma_scan: SD Vm memory model, randomized backpressure,
// expected reads/clears/spikes derived from the firing rule over the memory image.
module tb_soma_scan;
   localparam int NNW   = 12;
   localparam int VW    = 20;
   localparam int DEPTH = 1 << NNW;

   logic           clk_SD = 1'b0;
   logic           rst_n = 1'b0;
   logic           tik = 1'b0;
   logic           cfg_en = 1'b0;
   logic [NNW-1:0] cfg_neuron_max = '0;
   logic [VW-1:0]  cfg_vth = '0;
   logic [NNW-1:0] soma_sd_vm_addr;
   logic           soma_sd_vld;
   logic           soma_sd_clear;
   logic [VW-1:0]  sd_soma_vm = '0;
   logic [NNW-1:0] spk_id;
   logic           spk_vld;
   logic           spk_rdy = 1'b0;
   logic           busy;
   logic           done;
   logic           overrun;

   soma_scan #(.NNW(NNW), .VW(VW)) dut (
      .clk_SD(clk_SD), .rst_n(rst_n), .tik(tik), .cfg_en(cfg_en),
      .cfg_neuron_max(cfg_neuron_max), .cfg_vth(cfg_vth),
      .soma_sd_vm_addr(soma_sd_vm_addr), .soma_sd_vld(soma_sd_vld),
      .soma_sd_clear(soma_sd_clear), .sd_soma_vm(sd_soma_vm),
      .spk_id(spk_id), .spk_vld(spk_vld), .spk_rdy(spk_rdy),
      .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 clk_SD = ~clk_SD;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int tik_cyc, done_cyc, done_cnt, busy_cnt, last_acc_cyc, idle_cyc;
   int spk_cnt = 0;
   int clr_cnt = 0;
   int rdy_mode = 0;

   logic signed [VW-1:0] vm_mem  [DEPTH];
   logic signed [VW-1:0] ref_mem [DEPTH];
   int wq_a[$], wq_v[$];
   int exp_spk[$], exp_clr[$], exp_rd[$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_SD);
         #1;
      end
   endtask

   task automatic set_vm(input int i, input int v);
      wq_a.push_back(i);
      wq_v.push_back(v);
      ref_mem[i] = VW'(v);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_spk_vld"}, spk_vld, 0);
      chk({tag, "_spk_id"}, spk_id, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_overrun"}, overrun, 0);
      chk({tag, "_sd_vld"}, soma_sd_vld, 0);
      chk({tag, "_sd_clear"}, soma_sd_clear, 0);
      chk({tag, "_sd_addr"}, soma_sd_vm_addr, 0);
   endtask

   // Issues a tik (DUT assumed idle) and records what the scan must produce.
   task automatic start_scan(input int mx, input int vth, input bit scramble_en);
      cfg_neuron_max = NNW'(mx);
      cfg_vth        = VW'(vth);
      cfg_en         = 1'b1;
      tik            = 1'b1;
      for (int i = 0; i <= mx; i++) begin
         exp_rd.push_back(i);
         if (int'(ref_mem[i]) >= vth) begin
            exp_spk.push_back(i);
            exp_clr.push_back(i);
            ref_mem[i] = '0;
         end
      end
      done_cnt = 0;
      busy_cnt = 0;
      tik_cyc  = cyc;
      tick(1);
      tik            = 1'b0;
      cfg_neuron_max = NNW'($urandom);
      cfg_vth        = VW'($urandom);
      if (scramble_en) cfg_en = 1'($urandom_range(1));
   endtask

   task automatic wait_idle(input int budget);
      int n;
      int diffs;
      n = 0;
      while (busy === 1'b1 && n < budget) begin
         tick(1);
         n++;
      end
      if (busy !== 1'b0) chk("scan_timeout", n, -1);
      idle_cyc = cyc;
      tick(2);
      chk("spikes_missing", exp_spk.size(), 0);
      chk("clears_missing", exp_clr.size(), 0);
      chk("reads_missing", exp_rd.size(), 0);
      chk("done_pulses", done_cnt, 1);
      diffs = 0;
      for (int i = 0; i < DEPTH; i++)
         if (vm_mem[i] !== ref_mem[i]) diffs++;
      chk("vm_contents", diffs, 0);
   endtask

   initial forever begin
      @(posedge clk_SD);
      cyc++;
   end

   initial forever begin
      @(posedge clk_SD);
      #1;
      case (rdy_mode)
         0:       spk_rdy = 1'b1;
         1:       spk_rdy = 1'($urandom_range(1));
         default: spk_rdy = 1'b0;
      endcase
   end

   // SD model: read data appears the cycle after the strobe, garbage otherwise.
   initial begin
      bit rd, clr;
      int a;
      forever begin
         @(negedge clk_SD);
         while (wq_a.size() > 0) vm_mem[wq_a.pop_front()] = VW'(wq_v.pop_front());
         rd  = rst_n && soma_sd_vld && !soma_sd_clear;
         clr = rst_n && soma_sd_vld && soma_sd_clear;
         a   = int'(soma_sd_vm_addr);
         if (clr) vm_mem[a] = '0;
         @(posedge clk_SD);
         #1;
         sd_soma_vm = rd ? vm_mem[a] : VW'($urandom);
      end
   end

   // Monitor: pops expectations whenever the DUT presents a read, clear or spike.
   initial begin
      bit hold_pend, load_pend;
      int hold_id, load_id;
      hold_pend = 0;
      load_pend = 0;
      forever begin
         @(negedge clk_SD);
         if (!rst_n) begin
            hold_pend = 0;
            load_pend = 0;
         end else begin
            if (busy) busy_cnt++;
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (hold_pend) chk("spk_held_stable", spk_vld ? int'(spk_id) : -1, hold_id);
            if (load_pend) chk("clear_loads_spike", spk_vld ? int'(spk_id) : -1, load_id);
            hold_pend = spk_vld && !spk_rdy;
            hold_id   = int'(spk_id);
            load_pend = 0;
            if (soma_sd_vld) begin
               chk("sd_vld_only_when_busy", busy, 1);
               if (soma_sd_clear) begin
                  clr_cnt++;
                  load_pend = 1;
                  load_id   = int'(soma_sd_vm_addr);
                  if (exp_clr.size() == 0) chk("clear_unexpected", soma_sd_vm_addr, -1);
                  else chk("clear_addr", soma_sd_vm_addr, exp_clr.pop_front());
               end else begin
                  if (exp_rd.size() == 0) chk("read_unexpected", soma_sd_vm_addr, -1);
                  else chk("read_addr", soma_sd_vm_addr, exp_rd.pop_front());
               end
            end
            if (spk_vld && spk_rdy) begin
               spk_cnt++;
               last_acc_cyc = cyc;
               if (exp_spk.size() == 0) chk("spike_unexpected", spk_id, -1);
               else chk("spike_id", spk_id, exp_spk.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int c0, s0, mx, vth;
      for (int i = 0; i < DEPTH; i++) set_vm(i, int'($urandom_range(600)) - 300);
      rst_n = 1'b0;
      tick(3);
      chk_zero("reset");
      rst_n = 1'b1;
      tick(2);

      // tik with soma disabled
      cfg_en = 1'b0;
      tik = 1'b1;
      tick(1);
      tik = 1'b0;
      tick(3);
      chk("disabled_busy", busy, 0);
      chk("disabled_overrun", overrun, 0);

      // basic fire
      set_vm(0, 50); set_vm(1, 100); set_vm(2, -5); set_vm(3, 200);
      tick(1);
      start_scan(3, 100, 0);
      wait_idle(100);
      chk("basic_done_latency", done_cyc - tik_cyc, 9);

      // no fire
      set_vm(0, 10); set_vm(1, -3); set_vm(2, 99); set_vm(3, 0);
      tick(1);
      c0 = clr_cnt; s0 = spk_cnt;
      start_scan(3, 100, 0);
      wait_idle(100);
      chk("nofire_clears", clr_cnt - c0, 0);
      chk("nofire_spikes", spk_cnt - s0, 0);
      chk("nofire_done_latency", done_cyc - tik_cyc, 9);
      chk("nofire_busy_cycles", busy_cnt, 9);

      // single neuron
      set_vm(0, 7);
      tick(1);
      start_scan(0, 5, 0);
      wait_idle(50);
      chk("single_done_latency", done_cyc - tik_cyc, 3);

      // signed compare
      set_vm(0, -11); set_vm(1, -10); set_vm(2, 'h7FFFF);
      tick(1);
      s0 = spk_cnt;
      start_scan(2, -10, 0);
      wait_idle(50);
      chk("signed_spikes", spk_cnt - s0, 2);

      // tik coincident with done
      set_vm(0, 0); set_vm(1, 0);
      tick(1);
      chk("pre_coincide_overrun", overrun, 0);
      start_scan(1, 1000, 0);
      tick(4);
      chk("coincide_done", done, 1);
      tik = 1'b1;
      tick(1);
      tik = 1'b0;
      wait_idle(50);
      chk("coincide_overrun", overrun, 1);
      tick(3);
      chk("coincide_no_rescan", busy, 0);

      rst_n = 1'b0;
      tick(2);
      chk_zero("reset2");
      rst_n = 1'b1;
      tick(2);

      // backpressure
      for (int i = 0; i < 4; i++) set_vm(i, 300 + i);
      rdy_mode = 2;
      tick(1);
      s0 = spk_cnt;
      start_scan(3, 100, 0);
      tick(9);
      rdy_mode = 0;
      wait_idle(200);
      chk("bp_spikes", spk_cnt - s0, 4);
      chk("bp_busy_after_accept", idle_cyc > last_acc_cyc, 1);

      // overrun: second tik 3 cycles after the first
      set_vm(0, 50); set_vm(1, 100); set_vm(2, -5); set_vm(3, 200);
      tick(1);
      start_scan(3, 100, 0);
      tick(2);
      tik = 1'b1;
      tick(1);
      tik = 1'b0;
      wait_idle(100);
      chk("overrun_done_latency", done_cyc - tik_cyc, 9);
      chk("overrun_set", overrun, 1);
      tick(5);
      chk("overrun_sticky", overrun, 1);

      // random scans with backpressure and cfg changes after the tik
      for (int s = 0; s < 8; s++) begin
         mx  = int'($urandom_range(15));
         vth = int'($urandom_range(400)) - 200;
         for (int i = 0; i <= mx; i++) begin
            if ($urandom_range(3) == 0) set_vm(i, int'($urandom_range(1048575)) - 524288);
            else set_vm(i, int'($urandom_range(600)) - 300);
         end
         rdy_mode = 1;
         tick(1);
         start_scan(mx, vth, 1);
         wait_idle(2000);
      end

      // full address range
      for (int i = 0; i < DEPTH; i++) set_vm(i, int'($urandom_range(1048575)) - 524288);
      rdy_mode = 1;
      tick(1);
      start_scan(DEPTH - 1, 0, 1);
      wait_idle(60000);

      // reset during HOLD
      for (int i = 0; i < 4; i++) set_vm(i, 300);
      rdy_mode = 2;
      tick(1);
      start_scan(3, 100, 0);
      tick(5);
      chk("hold_spk_vld", spk_vld, 1);
      chk("hold_no_sd_access", soma_sd_vld, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("rst_mid");
      exp_spk.delete(); exp_clr.delete(); exp_rd.delete();
      for (int i = 1; i < 4; i++) ref_mem[i] = VW'(300);
      tick(2);
      chk("rst_hold_sd_vld", soma_sd_vld, 0);
      rst_n = 1'b1;
      tick(2);
      chk("post_rst_sd_vld", soma_sd_vld, 0);
      chk("post_rst_busy", busy, 0);
      rdy_mode = 0;
      s0 = spk_cnt;
      start_scan(3, 100, 0);
      wait_idle(100);
      chk("post_rst_spikes", spk_cnt - s0, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/soma_scan.md
Name: soma_scan

Overview:
- Downstream consumer of the synapse-dendrite (SD) stage in the neuron node.
- On each `tik`, sequentially scans every configured neuron's membrane potential out of the SD Vm buffer and compares it against a threshold.
- For each firing neuron, commands SD to clear that Vm and emits the neuron index as a spike event, via valid/ready, to the downstream spike encoder/router.

Parameters:
- NNW, 12, neuron number/address width.
- VW, 20, Vm width; two's-complement signed.

Ports:
- clk_SD  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- tik  in  1  timestep pulse; starts a scan
- cfg_en  in  1  soma enable; tik is ignored when 0
- cfg_neuron_max  in  NNW  index of last neuron to scan (neurons 0..cfg_neuron_max)
- cfg_vth  in  VW  signed firing threshold
- soma_sd_vm_addr  out  NNW  Vm address to SD
- soma_sd_vld  out  1  SD access strobe (read when clear=0, clear-write when clear=1)
- soma_sd_clear  out  1  request SD to write 0 to soma_sd_vm_addr
- sd_soma_vm  in  VW  Vm read data; valid one cycle after a read strobe
- spk_id  out  NNW  firing neuron index
- spk_vld  out  1  spike valid
- spk_rdy  in  1  downstream ready
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan end
- overrun  out  1  sticky: tik arrived while busy

Behaviour:
- Reset values: all outputs 0; state IDLE; neuron counter 0; spike register empty.
- cfg_* inputs are sampled at scan start and held internally for the whole scan.
- Notation: "n" is the neuron counter.

State machine:
- IDLE
  - tik & cfg_en -> READ, with n=0 and busy=1.
- READ (1 cycle)
  - Drives soma_sd_vm_addr=n, soma_sd_vld=1, soma_sd_clear=0.
  - -> EVAL.
- EVAL (1 cycle)
  - fire = signed(sd_soma_vm) >= signed(cfg_vth).
  - If fire and the spike register is empty, or is being accepted this cycle (spk_vld & spk_rdy):
    - load spk_id=n, spk_vld=1;
    - drive soma_sd_vm_addr=n, soma_sd_vld=1, soma_sd_clear=1.
  - If fire and the spike register is full and not being accepted:
    - latch fire -> HOLD;
    - no clear is issued yet.
  - If not fire: no SD access.
  - After handling (not HOLD):
    - n==cfg_neuron_max -> FIN;
    - otherwise n++ and -> READ.
- HOLD
  - Wait until spk_rdy.
  - In the accept cycle: load the new spike, issue the clear as in EVAL, then advance as in EVAL.
- FIN
  - done=1 for one cycle.
  - busy stays 1 until the spike register drains (spk_vld=0), then -> IDLE with busy=0.
  - done is asserted in the first FIN cycle only.

Timing:
- Per non-stalled neuron: 2 cycles.
- Scan of N neurons with no backpressure: busy for 2N+1 cycles.
- First READ occurs the cycle after tik.

Spike handshake:
- spk_vld stays high, with spk_id stable, until spk_vld & spk_rdy.
- Single-entry register.
- spk_rdy may be high while spk_vld is 0 without effect.

Boundary conditions:
- tik while busy: ignored, scan continues, overrun set (cleared only by reset).
- tik and done coincident: tik is ignored and overrun is set.
- cfg_neuron_max=0: a single-neuron scan.
- Counter never wraps; cfg_neuron_max = 2^NNW-1 scans all addresses and terminates.
- Vm exactly equal to vth fires; negative Vm never fires if vth >= 0.
- cfg_en deasserted mid-scan: the current scan completes.
- Reset mid-scan: immediate return to IDLE; spike dropped; no SD strobe in the following cycles.
- Only one SD access per cycle; soma_sd_vld is never asserted in IDLE/FIN.

Test Plan:
- Basic fire:
  - Stimulus: cfg_neuron_max=3, vth=100, Vm={50,100,-5,200}, spk_rdy=1, tik.
  - Response: spikes id 1 then 3; clears to addr 1 and 3; done exactly 9 cycles after tik; Vm afterwards {50,0,-5,0}.
- No fire:
  - Stimulus: all Vm < vth.
  - Response: no spk_vld; soma_sd_clear never 1; done after 2N+1 cycles.
- Backpressure:
  - Stimulus: all 4 neurons fire, spk_rdy=0 for 10 cycles then 1.
  - Response: ids 0,1,2,3 in order, none lost or duplicated; clear for neuron k coincides with loading spike k; busy drops only after the last accept.
- Overrun:
  - Stimulus: second tik 3 cycles after the first.
  - Response: scan unaffected; overrun=1 and stays 1.
- Signed compare:
  - Stimulus: vth=-10, Vm={-11,-10,0x7FFFF}.
  - Response: spikes id 1 and 2 only.
- Reset mid-scan:
  - Stimulus: assert rst_n=0 during HOLD.
  - Response: all outputs 0 immediately; a new tik after release starts cleanly at n=0.
